int_arbiter: RTL

Interrupt arbiter and sequencer for the single-cycle CPU. It sits between the four external interrupt lines and the control unit, and latches rising edges into per-line pending bits. It selects one eligible line, raises a request to the control unit and supplies the 10-bit handler vector that the datapath loads into the PC. It tracks the in-service interrupt until the handler signals end-of-interrupt, and it does not allow nesting.

---
 rtl/int_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/int_arbiter.sv
// Interrupt arbiter/sequencer: latches irq rising edges, grants one line at a time, no nesting.
// Define INT_ROUND_ROBIN_EN for rotating priority; otherwise irq[0] has fixed highest priority.
module int_arbiter #(
    parameter int unsigned    AW         = 10,
    parameter logic [AW-1:0]  VEC_BASE   = 10'h3F0,
    parameter int unsigned    VEC_STRIDE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    irq,
    input  logic          mask_we,
    input  logic [3:0]    mask_in,
    input  logic          int_ack,
    input  logic          fin_int,
    output logic          int_req,
    output logic [AW-1:0] vector,
    output logic [3:0]    pending,
    output logic [3:0]    in_service,
    output logic [3:0]    lost
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]    state, state_next;
    logic [3:0]    irq_q;
    logic [3:0]    mask, mask_next;
    logic [1:0]    win, win_next;
    logic          req_next;
    logic [AW-1:0] vec_next;
    logic [3:0]    pending_next, in_service_next, lost_next;

    logic [3:0]    rise;
    logic [3:0]    eligible;
    logic [3:0]    ack_clr;
    logic [1:0]    search_start;
    logic [1:0]    win_sel;
    logic [1:0]    idx;
    logic          found;
    logic [AW-1:0] vec_calc;

`ifdef INT_ROUND_ROBIN_EN
    logic [1:0] rr_ptr, rr_next;
    assign search_start = rr_ptr + 2'd1;
`else
    assign search_start = 2'd0;
`endif

    assign rise     = irq & ~irq_q;
    assign eligible = pending & mask;

    // Wrapping search over eligible lines, beginning at search_start.
    always_comb begin
        found   = 1'b0;
        win_sel = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = search_start + 2'(k);
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_sel = idx;
            end
        end
    end

    assign vec_calc = VEC_BASE + AW'(32'(win_sel) * VEC_STRIDE);

    always_comb begin
        state_next      = state;
        win_next        = win;
        req_next        = int_req;
        vec_next        = vector;
        in_service_next = in_service;
        ack_clr         = 4'b0000;
`ifdef INT_ROUND_ROBIN_EN
        rr_next         = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    win_next   = win_sel;
                    vec_next   = vec_calc;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_clr         = 4'b0001 << win;
                    in_service_next = 4'b0001 << win;
                    req_next        = 1'b0;
                    state_next      = SERVICE;
`ifdef INT_ROUND_ROBIN_EN
                    rr_next         = win;
`endif
                end else if (!mask[win]) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (fin_int) begin
                    in_service_next = 4'b0000;
                    state_next      = IDLE;
                end
            end
            default: begin
                req_next        = 1'b0;
                in_service_next = 4'b0000;
                state_next      = IDLE;
            end
        endcase

        // A rise on the line being acked re-pends it without counting as lost.
        pending_next = (pending & ~ack_clr) | rise;
        lost_next    = mask_we ? 4'b0000 : (lost | (rise & pending & ~ack_clr));
        mask_next    = mask_we ? mask_in : mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_q      <= 4'b0000;
            mask       <= 4'b1111;
            win        <= 2'd0;
            int_req    <= 1'b0;
            vector     <= '0;
            pending    <= 4'b0000;
            in_service <= 4'b0000;
            lost       <= 4'b0000;
        end else begin
            state      <= state_next;
            irq_q      <= irq;
            mask       <= mask_next;
            win        <= win_next;
            int_req    <= req_next;
            vector     <= vec_next;
            pending    <= pending_next;
            in_service <= in_service_next;
            lost       <= lost_next;
        end
    end

`ifdef INT_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 2'd3;
        end else begin
            rr_ptr <= rr_next;
        end
    end
`endif

endmodule
